cpu_controller: RTL and testbench
=================================

# cpu_controller

Moore state machine that sequences the CPU datapath for one instruction at a time. It sits inside `cpu`, between the instruction decoder and the datapath. It takes the decoded opcode/op fields and the start input `s`, and drives the register-file, pipeline-register, mux-select and status-load controls. It reports completion on `w`, which is shown on LEDR[9].

## Interface
- Parameters: none; the instruction encoding is fixed.
- `clk`  in  1  rising-edge clock; on the board this is ~KEY[0].
- `reset`  in  1  asynchronous, active-high; forces WAIT.
- `s`  in  1  start request, level-sensitive.
- `opcode`  in  3  instruction bits [15:13] from the decoder.
- `op`  in  2  instruction bits [12:11] from the decoder.
- `w`  out  1  high only in WAIT; idle and ready for `s`.
- `nsel`  out  3  one-hot register-file index select: [2]=Rn, [1]=Rd, [0]=Rm; 000 when unused.
- `vsel`  out  4  one-hot writeback source: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C; 0000 when not writing.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for registers A, B, C and the status register.
- `asel`  out  1  1 selects 16'b0 in place of A at the ALU input.
- `bsel`  out  1  1 selects sximm5 in place of shifted B; always 0 for this ISA.
- `illegal`  out  1  one-cycle pulse on an unsupported {opcode,op}.

## Operation
- On WAIT & `s`, {opcode,op} is captured into an internal 5-bit register `ins`. Later states decode only `ins`, so changing `in`/`load` mid-instruction has no effect. `ins` resets to 0.
- Strobe defaults: all strobes, `asel`, `bsel` = 0; `nsel` = 000; `vsel` = 0000. Each state asserts only what is listed below.
- States:
  - WAIT: `w`=1. Go to DECODE if `s`, else stay.
  - DECODE: dispatch on `ins`:
    - 110_10 (MOV Rn,#imm8) → WIMM
    - 110_00 (MOV Rd,Rm{,sh}) → GETB
    - 101_11 (MVN) → GETB
    - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) → GETA
    - anything else → WAIT with `illegal`=1 this cycle.
  - WIMM: `nsel`=100, `vsel`=0100, `write`=1 → WAIT.
  - GETA: `nsel`=100, `loada`=1 → GETB.
  - GETB: `nsel`=001, `loadb`=1 → CMP if `ins`=101_01, else ALU.
  - ALU: `loadc`=1; `asel`=1 for MOV reg (ALU op 00 gives 0+shifted B), else 0 → WREG.
  - CMP: `loads`=1, `asel`=0 → WAIT. C is not loaded and no register is written.
  - WREG: `nsel`=010, `vsel`=0001, `write`=1 → WAIT.
- Only CMP loads status. ADD/AND/MVN/MOV leave Z/N/V unchanged.
- Outputs are a pure function of state plus `ins`; no input reaches an output combinationally.

## Timing
- Count edges from the edge that samples WAIT & `s` (edge 0). `w` falls after edge 0 and rises after:
  - MOV imm: edge 3
  - MOV reg, MVN: edge 5
  - CMP: edge 5
  - ADD, AND: edge 6
  - illegal: edge 2
- Register-file writes land on the edge that leaves WIMM/WREG. Status is updated on the edge that leaves CMP.
- `s` held high: a new instruction starts on the first edge that finds WAIT & `s`. Back-to-back execution is legal with no dead cycle beyond WAIT. `s` is ignored outside WAIT.
- Reset, asserted at any time:
  - immediately forces WAIT and `ins`=0;
  - immediately drops all strobes (`w`=1, `illegal`=0);
  - an in-flight write or load is aborted.
- After reset deasserts, the first possible start is the next edge sampling `s`.

## Test plan
- Reset mid-ADD (in GETB): without a clock edge, `w`=1 and `loadb`=0 immediately. The next `s` starts cleanly at DECODE.
- MOV R0,#7 (`ins`=110_10), `s` pulsed 1 cycle: WIMM asserts `write`=1, `vsel`=0100, `nsel`=100. `w` returns on edge 3. Datapath R0=0x0007.
- ADD R2,R1,R0 with R1=3, R0=7: the sequence GETA→GETB→ALU→WREG asserts `loada`, `loadb`, `loadc`, `write` in order. `w` returns on edge 6. Out=0x000A, status unchanged.
- CMP R1,R1: `loads`=1 only in CMP; `loadc` and `write` never asserted. Z=1, N=0, V=0, and `w` returns on edge 5.
- `opcode`=111 with `s`: `illegal`=1 for exactly one cycle in DECODE, with no write/load strobes. `w` returns on edge 2.
- `s` held high across MOV reg then changed `in` mid-instruction: the first instruction completes per its latched `ins` with `asel`=1 in ALU. The second starts on the edge after WAIT is re-entered.

Source files
------------

// File: rtl/cpu_controller.sv
// Instruction sequencer for the CPU datapath: one instruction at a time,
// Moore-style, with every control output registered.
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    localparam int unsigned INS_W  = 5;
    localparam int unsigned NSEL_W = 3;
    localparam int unsigned VSEL_W = 4;

    localparam logic [INS_W-1:0] INS_MOV_IMM = 5'b110_10;
    localparam logic [INS_W-1:0] INS_MOV_REG = 5'b110_00;
    localparam logic [INS_W-1:0] INS_MVN     = 5'b101_11;
    localparam logic [INS_W-1:0] INS_ADD     = 5'b101_00;
    localparam logic [INS_W-1:0] INS_CMP     = 5'b101_01;
    localparam logic [INS_W-1:0] INS_AND     = 5'b101_10;

    localparam logic [NSEL_W-1:0] NSEL_RN = 3'b100;
    localparam logic [NSEL_W-1:0] NSEL_RD = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RM = 3'b001;

    localparam logic [VSEL_W-1:0] VSEL_IMM8 = 4'b0100;
    localparam logic [VSEL_W-1:0] VSEL_C    = 4'b0001;

    // LATCH is the cycle after ins is captured; DECODE dispatches on ins.
    typedef enum logic [3:0] {
        ST_WAIT,
        ST_LATCH,
        ST_DECODE,
        ST_WIMM,
        ST_GETA,
        ST_GETB,
        ST_ALU,
        ST_CMP,
        ST_WREG
    } state_t;

    typedef struct packed {
        logic              w;
        logic [NSEL_W-1:0] nsel;
        logic [VSEL_W-1:0] vsel;
        logic              write;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              asel;
        logic              bsel;
        logic              illegal;
    } ctrl_t;

    state_t           state;
    state_t           state_nxt;
    logic [INS_W-1:0] ins;
    logic [INS_W-1:0] ins_nxt;
    ctrl_t            ctrl;

    function automatic logic is_legal(input logic [INS_W-1:0] i);
        return (i == INS_MOV_IMM) || (i == INS_MOV_REG) || (i == INS_MVN) ||
               (i == INS_ADD) || (i == INS_CMP) || (i == INS_AND);
    endfunction

    // Control word for a given state; strobes default low, w only in WAIT.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [INS_W-1:0] i);
        ctrl_t c;
        c = '0;
        case (st)
            ST_WAIT:   c.w = 1'b1;
            ST_DECODE: c.illegal = !is_legal(i);
            ST_WIMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            ST_GETA: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            ST_GETB: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            ST_ALU: begin
                c.loadc = 1'b1;
                c.asel  = (i == INS_MOV_REG);
            end
            ST_CMP:    c.loads = 1'b1;
            ST_WREG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Next state and instruction capture.
    always_comb begin
        state_nxt = state;
        ins_nxt   = ins;
        case (state)
            ST_WAIT: begin
                if (s) begin
                    state_nxt = ST_LATCH;
                    ins_nxt   = {opcode, op};
                end
            end
            ST_LATCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (ins)
                    INS_MOV_IMM:                state_nxt = ST_WIMM;
                    INS_MOV_REG, INS_MVN:       state_nxt = ST_GETB;
                    INS_ADD, INS_CMP, INS_AND:  state_nxt = ST_GETA;
                    default:                    state_nxt = ST_WAIT;
                endcase
            end
            ST_WIMM:   state_nxt = ST_WAIT;
            ST_GETA:   state_nxt = ST_GETB;
            ST_GETB:   state_nxt = (ins == INS_CMP) ? ST_CMP : ST_ALU;
            ST_ALU:    state_nxt = ST_WREG;
            ST_CMP:    state_nxt = ST_WAIT;
            ST_WREG:   state_nxt = ST_WAIT;
            default:   state_nxt = ST_WAIT;
        endcase
    end

    // Controls are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
            ins   <= '0;
            ctrl  <= ctrl_for(ST_WAIT, '0);
        end else begin
            state <= state_nxt;
            ins   <= ins_nxt;
            ctrl  <= ctrl_for(state_nxt, ins_nxt);
        end
    end

    assign w       = ctrl.w;
    assign nsel    = ctrl.nsel;
    assign vsel    = ctrl.vsel;
    assign write   = ctrl.write;
    assign loada   = ctrl.loada;
    assign loadb   = ctrl.loadb;
    assign loadc   = ctrl.loadc;
    assign loads   = ctrl.loads;
    assign asel    = ctrl.asel;
    assign bsel    = ctrl.bsel;
    assign illegal = ctrl.illegal;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle control words checked against
// hand-computed expectations for each instruction class, reset and s handling.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel, illegal;

    logic [15:0] ctrl;
    logic [15:0] seq [9];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    // {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal}
    localparam logic [15:0] C_WAIT = 16'h8000;
    localparam logic [15:0] C_NONE = 16'h0000;
    localparam logic [15:0] C_WIMM = 16'h4480;
    localparam logic [15:0] C_GETA = 16'h4040;
    localparam logic [15:0] C_GETB = 16'h1020;
    localparam logic [15:0] C_ALU  = 16'h0010;
    localparam logic [15:0] C_ALUM = 16'h0014;
    localparam logic [15:0] C_CMP  = 16'h0008;
    localparam logic [15:0] C_WREG = 16'h2180;
    localparam logic [15:0] C_ILL  = 16'h0001;

    cpu_controller dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .illegal (illegal)
    );

    assign ctrl = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one instruction with a one-cycle s pulse, scramble the inputs
    // afterwards, then compare the control word after edges 0..n-1.
    task automatic run(input string name, input logic [2:0] oc, input logic [1:0] o, input int n);
        opcode = oc;
        op     = o;
        s      = 1'b1;
        tick();
        s      = 1'b0;
        opcode = 3'b111;
        op     = 2'b11;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            check($sformatf("%s_e%0d", name, i), ctrl, seq[i]);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check("reset_async", ctrl, C_WAIT);
        tick();
        tick();
        check("reset_held", ctrl, C_WAIT);
        reset = 1'b0;
        tick();
        check("idle_no_s", ctrl, C_WAIT);

        seq = '{C_NONE, C_NONE, C_WIMM, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("mov_imm", 3'b110, 2'b10, 4);

        seq = '{C_NONE, C_NONE, C_GETA, C_GETB, C_ALU, C_WREG, C_WAIT, C_WAIT, C_WAIT};
        run("add", 3'b101, 2'b00, 7);

        seq = '{C_NONE, C_NONE, C_GETA, C_GETB, C_CMP, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("cmp", 3'b101, 2'b01, 6);

        seq = '{C_NONE, C_NONE, C_GETA, C_GETB, C_ALU, C_WREG, C_WAIT, C_WAIT, C_WAIT};
        run("and", 3'b101, 2'b10, 7);

        seq = '{C_NONE, C_NONE, C_GETB, C_ALU, C_WREG, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("mvn", 3'b101, 2'b11, 6);

        seq = '{C_NONE, C_NONE, C_GETB, C_ALUM, C_WREG, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("mov_reg", 3'b110, 2'b00, 6);

        seq = '{C_NONE, C_ILL, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("ill_111", 3'b111, 2'b00, 3);
        run("ill_110_01", 3'b110, 2'b01, 3);
        run("ill_000", 3'b000, 2'b00, 3);

        // Reset mid-ADD while in GETB, with no clock edge.
        opcode = 3'b101;
        op     = 2'b00;
        s      = 1'b1;
        tick();
        s      = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_getb", ctrl, C_GETB);
        #1 reset = 1'b1;
        #1 check("rst_mid_async", ctrl, C_WAIT);
        tick();
        check("rst_mid_held", ctrl, C_WAIT);
        reset = 1'b0;
        seq = '{C_NONE, C_NONE, C_WIMM, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT, C_WAIT};
        run("post_rst_mov", 3'b110, 2'b10, 4);

        // s held high: MOV reg completes on its latched ins, then an illegal
        // opcode presented mid-instruction starts right after WAIT.
        opcode = 3'b110;
        op     = 2'b00;
        s      = 1'b1;
        tick();
        check("held_e0", ctrl, C_NONE);
        opcode = 3'b111;
        tick();
        check("held_e1", ctrl, C_NONE);
        tick();
        check("held_e2", ctrl, C_GETB);
        tick();
        check("held_e3_asel", ctrl, C_ALUM);
        tick();
        check("held_e4", ctrl, C_WREG);
        tick();
        check("held_e5", ctrl, C_WAIT);
        tick();
        check("held_e6", ctrl, C_NONE);
        s = 1'b0;
        tick();
        check("held_e7_ill", ctrl, C_ILL);
        tick();
        check("held_e8", ctrl, C_WAIT);
        tick();
        check("held_idle", ctrl, C_WAIT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
